// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared constants and state encodings for the CPU memory responder
package mem_bus_responder_pkg;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic [7:0] OP_NOP            = 8'hEA;
    localparam logic [7:0] FILL_BYTE_DEFAULT = OP_NOP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } resp_state_t;

    function automatic logic [15:0] bus_offset(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// rtl/mem_bus_ram.sv - DEPTH x 8 RAM, synchronous read, bus write has priority over preload write
module mem_bus_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          bus_we,
    input  logic [AW-1:0] bus_waddr,
    input  logic [7:0]    bus_wdata,
    input  logic          load_we,
    input  logic [AW-1:0] load_waddr,
    input  logic [7:0]    load_wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Read returns the pre-edge byte even when a write lands on the same index.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (load_we && !(bus_we && (bus_waddr == load_waddr))) begin
            mem[load_waddr] <= load_wdata;
        end
        if (bus_we) begin
            mem[bus_waddr] <= bus_wdata;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU bus responder with wait states and preload port; ROM_PROTECT_EN write-protects low bytes
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [7:0]  FILL_BYTE   = FILL_BYTE_DEFAULT,
    parameter int          ROM_SIZE    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic [15:0] bus_addr,
    input  logic        bus_rw,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdy,
    output logic        bus_ack,
    output logic        bus_err,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [15:0] DEPTH16   = 16'(DEPTH);

    resp_state_t state;
    logic [3:0]  wait_cnt;
    logic [15:0] lat_off;
    logic        lat_rw;
    logic [7:0]  lat_wdata;
    logic        rdata_from_ram;
    logic [7:0]  ram_rdata;

    logic        accept;
    logic        exec;
    logic [15:0] ex_off;
    logic        ex_rw;
    logic [7:0]  ex_wdata;
    logic        ex_mapped;
    logic        ex_prot;
    logic        ram_we;
    logic        ram_re;

    assign accept = bus_req && (state != ST_WAIT);

    // Zero wait states execute straight from the bus on the accept edge.
    always_comb begin
        exec     = 1'b0;
        ex_off   = lat_off;
        ex_rw    = lat_rw;
        ex_wdata = lat_wdata;
        if (WAIT_CYCLES == 0) begin
            exec     = accept;
            ex_off   = bus_offset(bus_addr, ADDR_BASE);
            ex_rw    = bus_rw;
            ex_wdata = bus_wdata;
        end else begin
            exec = (state == ST_WAIT) && (wait_cnt == 4'd0);
        end
    end

    assign ex_mapped = ex_off < DEPTH16;
`ifdef ROM_PROTECT_EN
    assign ex_prot = ex_off < 16'(ROM_SIZE);
`else
    assign ex_prot = 1'b0;
`endif
    assign ram_we = exec && (ex_rw == BUS_WRITE) && ex_mapped && !ex_prot;
    assign ram_re = exec && (ex_rw == BUS_READ) && ex_mapped;

    mem_bus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .bus_we     (ram_we),
        .bus_waddr  (ex_off[AW-1:0]),
        .bus_wdata  (ex_wdata),
        .load_we    (load_en),
        .load_waddr (load_addr[AW-1:0]),
        .load_wdata (load_data),
        .rd_en      (ram_re),
        .rd_addr    (ex_off[AW-1:0]),
        .rd_data    (ram_rdata)
    );

    // The RAM read register holds between reads, so a select flag is enough to hold bus_rdata.
    assign bus_rdata = rdata_from_ram ? ram_rdata : FILL_BYTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= 4'd0;
            lat_off        <= 16'd0;
            lat_rw         <= BUS_READ;
            lat_wdata      <= 8'd0;
            rdata_from_ram <= 1'b0;
            bus_rdy        <= 1'b1;
            bus_ack        <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            bus_ack <= exec;
            bus_err <= exec && (!ex_mapped || ((ex_rw == BUS_WRITE) && ex_prot));
            if (exec && (ex_rw == BUS_READ)) begin
                rdata_from_ram <= ex_mapped;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus_req) begin
                        lat_off   <= bus_offset(bus_addr, ADDR_BASE);
                        lat_rw    <= bus_rw;
                        lat_wdata <= bus_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            bus_rdy  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_DONE;
                        bus_rdy <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
